// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder: each stage resolves CHUNK sum bits and hands its carry to the next stage.
// Optional signed-overflow output is enabled by defining RCA_PIPE_OVF_EN.
module rca_pipe #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef RCA_PIPE_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int STAGES = (CHUNK > 0) ? WIDTH / CHUNK : 1;

  // Stage k receives WIDTH - k*CHUNK operand bits; these are packed back to back.
  function automatic int in_off(input int k);
    int o;
    o = 0;
    for (int j = 0; j < k; j++) o += WIDTH - j * CHUNK;
    return o;
  endfunction

  // Stage k holds (k+1)*CHUNK resolved sum bits; also packed back to back.
  function automatic int s_off(input int k);
    int o;
    o = 0;
    for (int j = 0; j < k; j++) o += (j + 1) * CHUNK;
    return o;
  endfunction

  localparam int IN_TOT = in_off(STAGES);
  localparam int S_TOT  = s_off(STAGES);

  if (CHUNK < 1 || WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_cfg_err
    $error("rca_pipe: WIDTH must be >= 2 and a multiple of CHUNK >= 1");
  end

  logic [IN_TOT-1:0] op_a_s;
  logic [IN_TOT-1:0] op_b_s;
  logic [S_TOT-1:0]  sum_s;
  logic [STAGES-1:0] valid_s;
  logic [STAGES-1:0] carry_s;
  logic              adv;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign op_a_s[WIDTH-1:0] = a;
  assign op_b_s[WIDTH-1:0] = b;

  assign out_valid = valid_s[STAGES-1];
  assign cout      = carry_s[STAGES-1];
  assign sum       = sum_s[S_TOT-1 -: WIDTH];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int IW = WIDTH - k * CHUNK;
    localparam int IO = in_off(k);
    localparam int SW = (k + 1) * CHUNK;
    localparam int SO = s_off(k);

    logic [IW-1:0]    a_in;
    logic [IW-1:0]    b_in;
    logic             c_in;
    logic             valid_d;
    logic [CHUNK-1:0] s_chunk;
    logic             carry_d;
    logic [SW-1:0]    sum_d;
    logic [SW-1:0]    sum_q;
    logic             valid_q;
    logic             carry_q;

    assign a_in = op_a_s[IO +: IW];
    assign b_in = op_b_s[IO +: IW];
    assign {carry_d, s_chunk} = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]}
                              + {{CHUNK{1'b0}}, c_in};

    if (k == 0) begin : g_head
      assign c_in    = cin;
      assign valid_d = in_valid;
      assign sum_d   = s_chunk;
    end else begin : g_body
      localparam int PSO = s_off(k - 1);
      assign c_in    = carry_s[k-1];
      assign valid_d = valid_s[k-1];
      assign sum_d   = {s_chunk, sum_s[PSO +: k*CHUNK]};
    end

    // NOTE: the datapath is reset along with the valid bits so sum/cout read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (adv) begin
        valid_q <= valid_d;
        carry_q <= carry_d;
        sum_q   <= sum_d;
      end
    end

    assign valid_s[k]      = valid_q;
    assign carry_s[k]      = carry_q;
    assign sum_s[SO +: SW] = sum_q;

    // Operand bits above this chunk travel on; the last stage has none left.
    if (IW > CHUNK) begin : g_fwd
      logic [IW-CHUNK-1:0] a_q;
      logic [IW-CHUNK-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[IW-1:CHUNK];
          b_q <= b_in[IW-1:CHUNK];
        end
      end

      assign op_a_s[IO+IW +: IW-CHUNK] = a_q;
      assign op_b_s[IO+IW +: IW-CHUNK] = b_q;
    end

`ifdef RCA_PIPE_OVF_EN
    // The sign bits are only consumed here, so overflow is resolved in the last stage.
    if (k == STAGES - 1) begin : g_ovf
      logic ovf_d;
      logic ovf_q;

      assign ovf_d = (a_in[IW-1] == b_in[IW-1]) && (s_chunk[CHUNK-1] != a_in[IW-1]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= ovf_d;
        end
      end

      assign ovf = ovf_q;
    end
`endif
  end

endmodule

// File: tb/tb_rca_pipe.sv
// Directed bench for rca_pipe (WIDTH=16, CHUNK=4): latency, back-to-back, backpressure and async reset.
module tb_rca_pipe;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef RCA_PIPE_OVF_EN
  logic             ovf;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rca_pipe #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef RCA_PIPE_OVF_EN
    .ovf       (ovf),
`endif
    .cout      (cout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] y, input logic c);
    in_valid = v;
    a        = x;
    b        = y;
    cin      = c;
  endtask

  task automatic expect_res(input string tag, input logic [15:0] s, input logic c, input logic v);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".sum"},   32'(sum),       32'(s));
    check({tag, ".cout"},  32'(cout),      32'(c));
`ifdef RCA_PIPE_OVF_EN
    check({tag, ".ovf"},   32'(ovf),       32'(v));
`endif
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);

    // Reset state
    #12;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.sum",       32'(sum),       32'd0);
    check("rst.cout",      32'(cout),      32'd0);
`ifdef RCA_PIPE_OVF_EN
    check("rst.ovf",       32'(ovf),       32'd0);
`endif

    // Single transfer on first edge after release, 4-edge latency
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 16'hFFFF, 16'h0001, 1'b0);
    #1;
    check("rel.in_ready", 32'(in_ready), 32'd1);
    cyc();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    check("lat1.valid", 32'(out_valid), 32'd0);
    cyc();
    check("lat2.valid", 32'(out_valid), 32'd0);
    cyc();
    check("lat3.valid", 32'(out_valid), 32'd0);
    cyc();
    expect_res("wrap", 16'h0000, 1'b1, 1'b0);
    cyc();
    check("wrap.nodup", 32'(out_valid), 32'd0);

    // Back-to-back transfers, consecutive results
    drive(1'b1, 16'h1234, 16'h1111, 1'b0);
    cyc();
    drive(1'b1, 16'h7FFF, 16'h0001, 1'b0);
    cyc();
    drive(1'b1, 16'h8000, 16'h8000, 1'b1);
    cyc();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    cyc();
    expect_res("b2b0", 16'h2345, 1'b0, 1'b0);
    cyc();
    expect_res("b2b1", 16'h8000, 1'b0, 1'b1);
    cyc();
    expect_res("b2b2", 16'h0001, 1'b1, 1'b1);
    cyc();
    check("b2b.drain", 32'(out_valid), 32'd0);

    // Backpressure: hold X1 for 5 cycles while X4 waits at the input
    drive(1'b1, 16'h00FF, 16'h0F01, 1'b0);
    cyc();
    drive(1'b1, 16'hABCD, 16'h5433, 1'b1);
    cyc();
    drive(1'b1, 16'h8000, 16'hFFFF, 1'b0);
    cyc();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    cyc();
    expect_res("bp.x1", 16'h1000, 1'b0, 1'b0);
    out_ready = 1'b0;
    drive(1'b1, 16'h4000, 16'h4000, 1'b1);
    #1;
    check("bp.in_ready_comb", 32'(in_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      expect_res($sformatf("bp.hold%0d", i), 16'h1000, 1'b0, 1'b0);
      check($sformatf("bp.in_ready%0d", i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    cyc();
    expect_res("bp.x2", 16'h0001, 1'b1, 1'b0);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    cyc();
    expect_res("bp.x3", 16'h7FFF, 1'b1, 1'b1);
    cyc();
    check("bp.bubble", 32'(out_valid), 32'd0);
    cyc();
    expect_res("bp.x4", 16'h8001, 1'b0, 1'b1);
    cyc();
    check("bp.drain", 32'(out_valid), 32'd0);

    // Asynchronous reset with a held result and one more in flight
    drive(1'b1, 16'h1111, 16'h2222, 1'b0);
    cyc();
    drive(1'b1, 16'h0001, 16'h0002, 1'b0);
    cyc();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    cyc();
    cyc();
    expect_res("ar.y1", 16'h3333, 1'b0, 1'b0);
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar.out_valid", 32'(out_valid), 32'd0);
    check("ar.sum",       32'(sum),       32'd0);
    check("ar.cout",      32'(cout),      32'd0);
    check("ar.in_ready",  32'(in_ready),  32'd1);

    // Release and accept Z on the very first edge; nothing stale may appear
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 16'hFFFF, 16'h0000, 1'b1);
    cyc();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    check("ar.post1", 32'(out_valid), 32'd0);
    cyc();
    check("ar.post2", 32'(out_valid), 32'd0);
    cyc();
    check("ar.post3", 32'(out_valid), 32'd0);
    cyc();
    expect_res("ar.z", 16'h0000, 1'b1, 1'b0);
    cyc();
    check("ar.post5", 32'(out_valid), 32'd0);
    cyc();
    check("ar.post6", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rca_pipe.md
RCA_PIPE -- requirements
Module: rca_pipe

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 Parameter CHUNK, default 4: carry-chain bits resolved per pipeline stage; STAGES = WIDTH/CHUNK.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand set on a, b, cin is valid.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a  input  WIDTH  addend A, unsigned bit vector.
REQ-008 b  input  WIDTH  addend B.
REQ-009 cin  input  1  carry into bit 0.
REQ-010 out_valid  output  1  sum, cout (and ovf) valid.
REQ-011 out_ready  input  1  downstream accepts result this cycle.
REQ-012 sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
REQ-013 cout  output  1  carry out of bit WIDTH-1.
REQ-014 ovf  output  1  signed overflow flag; present only with RCA_PIPE_OVF_EN.

Function
REQ-015 Pipeline of STAGES registered stages; stage k resolves sum bits [k*CHUNK +: CHUNK] from its operand slice and the carry registered by stage k-1 (stage 0 uses cin).
REQ-016 Each stage holds a valid bit, the already-resolved low sum bits, the unresolved high operand bits, and one carry bit; resolved and consumed bits need not be carried further.
REQ-017 Transfer in: in_valid && in_ready on a rising edge; transfer out: out_valid && out_ready.
REQ-018 Global advance enable adv = !out_valid || out_ready; all stages shift one position when adv = 1 and hold otherwise.
REQ-019 in_ready = adv, combinational; no dependency of in_ready on in_valid.
REQ-020 Latency: result of a transfer-in at edge N presents out_valid at edge N+STAGES-1 registered output, i.e. visible in the cycle after STAGES edges with adv = 1 throughout.
REQ-021 Throughput one result per cycle while out_ready = 1; bubbles (in_valid = 0) propagate as invalid slots and are not compressed.
REQ-022 While out_valid && !out_ready, sum, cout, ovf held bit-stable.
REQ-023 Results emerge strictly in acceptance order; no result dropped or duplicated.
REQ-024 Simultaneous transfer-in and transfer-out in one cycle is legal and loses nothing.
REQ-025 Arithmetic: {cout, sum} = a + b + cin evaluated at WIDTH+1 bits; wrap-around at 2^WIDTH reflected only in cout.
REQ-026 Elaboration error if WIDTH mod CHUNK != 0, CHUNK < 1, or WIDTH < 2.
REQ-027 STAGES = 1 degenerates to a single registered full-width adder with identical handshake.

Reset
REQ-028 rst_n low clears every stage valid bit immediately, independent of clk.
REQ-029 Reset values: out_valid 0, sum 0, cout 0, ovf 0; in_ready 1 once rst_n high.
REQ-030 Reset mid-operation discards all in-flight results; none emerge after release.
REQ-031 First transfer-in permitted on the first rising edge after rst_n deasserts.

Configuration
REQ-032 Macro RCA_PIPE_OVF_EN defined: port ovf present, ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]), pipelined and aligned with its sum, held under backpressure.
REQ-033 Macro RCA_PIPE_OVF_EN undefined: no ovf port, no sign-bit state stored; all other behaviour identical.

Verification (WIDTH=16, CHUNK=4, macro defined unless stated)
REQ-034 Reset release, a=0xFFFF, b=0x0001, cin=0, out_ready=1 -> after 4 edges out_valid=1, sum=0x0000, cout=1, ovf=0.
REQ-035 Back-to-back 0x1234+0x1111, 0x7FFF+0x0001, 0x8000+0x8000 cin=1 -> consecutive cycles: 0x2345/c0/v0, 0x8000/c0/v1, 0x0001/c1/v1.
REQ-036 Result pending, out_ready=0 for 5 cycles -> in_ready=0, sum/cout/ovf stable, no loss; out_ready=1 resumes order.
REQ-037 Two transfers in flight, rst_n pulsed low mid-cycle -> out_valid=0 immediately, no stale result after release.
REQ-038 Randomised 10000 transfers with random in_valid/out_ready vs. reference model, macro defined and undefined, CHUNK in {1,4,16} -> zero mismatches, order preserved.
